// File: rtl/operand_fetch_if.sv
// Pipeline handshake bundle around the operand-fetch stage.
//   Upstream side  : in_valid/in_ready handshake carrying in_instr and in_pc.
//   Downstream side: out_valid/out_ready slot carrying pc, instr, resolved
//                    operands and destination register toward execute.
// The "slave" modport is the stage itself; "master" is its environment,
// which feeds instructions in and consumes the slot.
interface operand_fetch_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [4:0]      out_rd;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val, out_rd
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val, out_rd
  );
endinterface

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage feeding the integer execute stage.
//   clk, rstn    : clock, asynchronous active-low reset
//   flush        : synchronous kill of stage contents
//   bus (slave)  : in_* upstream handshake, out_* execute slot
//   rf_rs*_addr  : register-file read addresses (instr[19:15], instr[24:20])
//   rf_rs*_data  : register-file read data (pre-write value in a write cycle)
//   ex_*         : EX-stage destination info for forwarding / load-use interlock
//   wb_*         : register-file write port, bypassed into the operands
//   bubble_cnt   : saturating count of load-use bubbles inserted

// Per-source operand resolver: x0, then EX (younger), then WB, then RF.
module operand_fetch_fwd #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_wen,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ex_is_load,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] val
);
  always_comb begin
    val = rf_data;
    if (addr == 5'd0)
      val = '0;
    else if (ex_wen && (ex_rd == addr) && !ex_is_load)
      val = ex_data;
    else if (wb_wen && (wb_rd == addr))
      // RF read is combinational but the write lands at the edge, so the
      // same-cycle write must be bypassed here.
      val = wb_data;
  end
endmodule

module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  operand_fetch_if.slave   bus,
  output logic [4:0]       rf_rs1_addr,
  output logic [4:0]       rf_rs2_addr,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic             ex_wen,
  input  logic [4:0]       ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             ex_is_load,
  input  logic             wb_wen,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam int NSRC = 2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd;
  } slot_t;

  // ---------------- decode ----------------
  logic [6:0]            opc;
  logic [NSRC-1:0]       src_used;
  logic                  writes_rd;
  logic [NSRC-1:0][4:0]  src_addr;
  logic [NSRC-1:0][XLEN-1:0] src_rf;
  logic [NSRC-1:0][XLEN-1:0] src_val;
  logic [NSRC-1:0]       src_luse;

  assign opc         = bus.in_instr[6:0];
  assign src_addr[0] = bus.in_instr[19:15];
  assign src_addr[1] = bus.in_instr[24:20];
  assign src_rf[0]   = rf_rs1_data;
  assign src_rf[1]   = rf_rs2_data;
  assign rf_rs1_addr = src_addr[0];
  assign rf_rs2_addr = src_addr[1];

  always_comb begin
    src_used  = '0;
    writes_rd = 1'b0;
    case (opc)
      OPC_OP:                src_used = 2'b11;
      OPC_STORE, OPC_BRANCH: src_used = 2'b11;
      OPC_OPIMM, OPC_LOAD,
      OPC_JALR:              src_used = 2'b01;
      default:               src_used = 2'b00;
    endcase
    case (opc)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR,
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      default:                     writes_rd = 1'b0;
    endcase
  end

  // ---------------- per-source resolve + load-use detect ----------------
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    operand_fetch_fwd #(.XLEN(XLEN)) u_fwd (
      .addr       (src_addr[s]),
      .rf_data    (src_rf[s]),
      .ex_wen     (ex_wen),
      .ex_rd      (ex_rd),
      .ex_data    (ex_data),
      .ex_is_load (ex_is_load),
      .wb_wen     (wb_wen),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .val        (src_val[s])
    );
    // Only sources the opcode actually reads can stall; loads to x0 never do.
    assign src_luse[s] = src_used[s] && (src_addr[s] == ex_rd);
  end

  logic hazard, hold;
  logic slot_vld;
  slot_t slot_q;

  assign hazard = bus.in_valid && ex_wen && ex_is_load && (ex_rd != 5'd0) && (|src_luse);
  assign hold   = slot_vld && !bus.out_ready;

  assign bus.in_ready = !flush && !hazard && !hold;

  // ---------------- slot register ----------------
  // Priority: flush > hold > hazard (bubble) > capture > drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_vld   <= 1'b0;
      slot_q     <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      slot_vld <= 1'b0;
    end else if (hold) begin
      slot_vld <= slot_vld;
    end else if (hazard) begin
      slot_vld <= 1'b0;
      if (bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (bus.in_valid) begin
      slot_vld       <= 1'b1;
      slot_q.pc      <= bus.in_pc;
      slot_q.instr   <= bus.in_instr;
      slot_q.rs1_val <= src_val[0];
      slot_q.rs2_val <= src_val[1];
      slot_q.rd      <= writes_rd ? bus.in_instr[11:7] : 5'd0;
    end else begin
      slot_vld <= 1'b0;
    end
  end

  assign bus.out_valid   = slot_vld;
  assign bus.out_pc      = slot_q.pc;
  assign bus.out_instr   = slot_q.instr;
  assign bus.out_rs1_val = slot_q.rs1_val;
  assign bus.out_rs2_val = slot_q.rs2_val;
  assign bus.out_rd      = slot_q.rd;
endmodule
